// File: rtl/spi_ram_pkg.sv
// Shared opcode encoding and output-state type for the SPI-driven RAM burst controller.
package spi_ram_pkg;

    localparam int unsigned OP_W = 2;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_WR_ADDR = 2'b00;
    localparam opcode_t OP_WR_DATA = 2'b01;
    localparam opcode_t OP_RD_ADDR = 2'b10;
    localparam opcode_t OP_RD_DATA = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/ram_sp_array.sv
// MEM_DEPTH x DATA_W storage: synchronous write, combinational read, contents never reset.
module ram_sp_array #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/spi_ram_burst.sv
// RAM controller decoding SPI command words into pointer loads, writes and handshaked reads.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              rd_drop,
    output logic              addr_err
);

    localparam int unsigned CMP_W = DATA_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    out_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [DATA_W-1:0] dout_d, rdata;
    logic              rd_drop_d, addr_err_d, mem_we;
    logic              rd_cmd, addr_ok;
    opcode_t           op;
    logic [DATA_W-1:0] payload;

    assign op      = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];
    // Rejects both stray upper bits and in-range-width values past the array end.
    assign addr_ok = {1'b0, payload} < CMP_W'(MEM_DEPTH);
    assign rd_cmd  = rx_valid && (op == OP_RD_DATA);

    assign wr_ptr_inc = (AUTO_INC == 0) ? wr_ptr_q :
                        (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
    assign rd_ptr_inc = (AUTO_INC == 0) ? rd_ptr_q :
                        (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);

    ram_sp_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (wr_ptr_q),
        .wdata  (payload),
        .raddr  (rd_ptr_q),
        .rdata_c(rdata)
    );

    // Command decode and output-buffer state machine.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dout_d     = dout;
        rd_drop_d  = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;

        if (rx_valid) begin
            unique case (op)
                OP_WR_ADDR: begin
                    if (addr_ok) wr_ptr_d = payload[ADDR_W-1:0];
                    else         addr_err_d = 1'b1;
                end
                OP_WR_DATA: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                end
                OP_RD_ADDR: begin
                    if (addr_ok) rd_ptr_d = payload[ADDR_W-1:0];
                    else         addr_err_d = 1'b1;
                end
                OP_RD_DATA: begin
                    if (state_q == EMPTY || tx_ready) begin
                        dout_d   = rdata;
                        rd_ptr_d = rd_ptr_inc;
                    end else begin
                        rd_drop_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            EMPTY:   if (rd_cmd) state_d = FULL;
            FULL:    if (tx_ready && !rd_cmd) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout     <= '0;
            rd_drop  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout     <= dout_d;
            rd_drop  <= rd_drop_d;
            addr_err <= addr_err_d;
        end
    end

    assign tx_valid = (state_q == FULL);

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: full-depth auto-increment instance plus a 200-word instance for range errors.
module tb_spi_ram_burst;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W+1:0] din_a = '0, din_b = '0;
    logic              rxv_a = 1'b0, rxv_b = 1'b0;
    logic              txr_a = 1'b1, txr_b = 1'b1;
    logic [DATA_W-1:0] dout_a, dout_b;
    logic              txv_a, txv_b, drop_a, drop_b, aerr_a, aerr_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .rx_valid(rxv_a), .tx_ready(txr_a),
        .dout(dout_a), .tx_valid(txv_a), .rd_drop(drop_a), .addr_err(aerr_a)
    );

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .rx_valid(rxv_b), .tx_ready(txr_b),
        .dout(dout_b), .tx_valid(txv_b), .rd_drop(drop_b), .addr_err(aerr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd_a(input logic [1:0] op, input logic [7:0] pl);
        din_a = {op, pl};
        rxv_a = 1'b1;
        @(posedge clk); #1;
        rxv_a = 1'b0;
        din_a = '0;
    endtask

    task automatic cmd_b(input logic [1:0] op, input logic [7:0] pl);
        din_b = {op, pl};
        rxv_b = 1'b1;
        @(posedge clk); #1;
        rxv_b = 1'b0;
        din_b = '0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        // reset values
        #7;
        chk("rst_dout", 32'(dout_a), 32'h00);
        chk("rst_txv", 32'(txv_a), 32'h0);
        chk("rst_drop", 32'(drop_a), 32'h0);
        chk("rst_aerr", 32'(aerr_a), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single write / read
        cmd_a(2'b00, 8'h10);
        cmd_a(2'b01, 8'hA5);
        cmd_a(2'b10, 8'h10);
        cmd_a(2'b11, 8'h00);
        chk("t1_dout", 32'(dout_a), 32'hA5);
        chk("t1_txv", 32'(txv_a), 32'h1);
        idle();
        chk("t1_txv_clr", 32'(txv_a), 32'h0);
        chk("t1_dout_hold", 32'(dout_a), 32'hA5);

        // burst with wrap past 0xFF
        cmd_a(2'b00, 8'hFE);
        cmd_a(2'b01, 8'h11);
        cmd_a(2'b01, 8'h22);
        cmd_a(2'b01, 8'h33);
        cmd_a(2'b10, 8'hFE);
        cmd_a(2'b11, 8'h00);
        chk("t2_rd0", 32'(dout_a), 32'h11);
        chk("t2_txv0", 32'(txv_a), 32'h1);
        cmd_a(2'b11, 8'h00);
        chk("t2_rd1", 32'(dout_a), 32'h22);
        chk("t2_txv1", 32'(txv_a), 32'h1);
        cmd_a(2'b11, 8'h00);
        chk("t2_rd2_wrap", 32'(dout_a), 32'h33);
        chk("t2_txv2", 32'(txv_a), 32'h1);
        idle();
        chk("t2_txv_clr", 32'(txv_a), 32'h0);

        // backpressure: second read dropped
        cmd_a(2'b00, 8'h11);
        cmd_a(2'b01, 8'h5C);
        txr_a = 1'b0;
        cmd_a(2'b10, 8'h10);
        cmd_a(2'b11, 8'h00);
        chk("t3_dout", 32'(dout_a), 32'hA5);
        chk("t3_drop_none", 32'(drop_a), 32'h0);
        cmd_a(2'b11, 8'h00);
        chk("t3_drop", 32'(drop_a), 32'h1);
        chk("t3_dout_hold", 32'(dout_a), 32'hA5);
        chk("t3_txv_hold", 32'(txv_a), 32'h1);
        idle();
        chk("t3_drop_pulse", 32'(drop_a), 32'h0);
        chk("t3_txv_stall", 32'(txv_a), 32'h1);
        txr_a = 1'b1;
        idle();
        chk("t3_txv_drain", 32'(txv_a), 32'h0);
        cmd_a(2'b11, 8'h00);
        chk("t3_rdptr_once", 32'(dout_a), 32'h5C);
        idle();

        // rx_valid low ignores a write opcode
        cmd_a(2'b00, 8'h12);
        cmd_a(2'b01, 8'h66);
        din_a = {2'b01, 8'hEE};
        rxv_a = 1'b0;
        idle();
        idle();
        din_a = '0;
        cmd_a(2'b01, 8'h77);
        cmd_a(2'b10, 8'h12);
        cmd_a(2'b11, 8'h00);
        chk("t4_rd12", 32'(dout_a), 32'h66);
        cmd_a(2'b11, 8'h00);
        chk("t4_rd13", 32'(dout_a), 32'h77);
        idle();

        // read-after-write in consecutive cycles
        cmd_a(2'b10, 8'h50);
        cmd_a(2'b00, 8'h50);
        cmd_a(2'b01, 8'hC3);
        cmd_a(2'b11, 8'h00);
        chk("t5_raw", 32'(dout_a), 32'hC3);
        idle();

        // 200-word instance: out-of-range address rejected
        cmd_b(2'b00, 8'h05);
        cmd_b(2'b00, 8'hC8);
        chk("t6_aerr", 32'(aerr_b), 32'h1);
        chk("t6_aerr_a_quiet", 32'(aerr_a), 32'h0);
        cmd_b(2'b01, 8'h4D);
        chk("t6_aerr_pulse", 32'(aerr_b), 32'h0);
        cmd_b(2'b10, 8'hFF);
        chk("t6_aerr_rd", 32'(aerr_b), 32'h1);
        cmd_b(2'b10, 8'h05);
        cmd_b(2'b11, 8'h00);
        chk("t6_wr_prev_ptr", 32'(dout_b), 32'h4D);
        cmd_b(2'b00, 8'hC7);
        cmd_b(2'b01, 8'h81);
        cmd_b(2'b01, 8'h82);
        cmd_b(2'b10, 8'hC7);
        cmd_b(2'b11, 8'h00);
        chk("t6_rd_c7", 32'(dout_b), 32'h81);
        cmd_b(2'b11, 8'h00);
        chk("t6_wrap199", 32'(dout_b), 32'h82);
        chk("t6_txv", 32'(txv_b), 32'h1);
        idle();

        // async reset while holding read data
        txr_a = 1'b0;
        cmd_a(2'b10, 8'hFE);
        cmd_a(2'b11, 8'h00);
        chk("t7_pre_dout", 32'(dout_a), 32'h11);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_txv", 32'(txv_a), 32'h0);
        chk("t7_rst_dout", 32'(dout_a), 32'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        txr_a = 1'b1;
        cmd_a(2'b11, 8'h00);
        chk("t7_rdptr0_mem", 32'(dout_a), 32'h33);
        cmd_a(2'b01, 8'h9A);
        cmd_a(2'b10, 8'h00);
        cmd_a(2'b11, 8'h00);
        chk("t7_wrptr0", 32'(dout_a), 32'h9A);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
